// File: rtl/fifo_tb_pkg.sv
// fifo_tb_pkg: shared FSM encoding, LFSR taps and phase attempt counts for the FIFO bench sequencer
package fifo_tb_pkg;
    typedef enum logic [2:0] {IDLE, FILL, OVERFILL, DRAIN, UNDERDRAIN, MIXED, DONE} state_e;
    // x^16+x^14+x^13+x^11+1 on a right-shifting register: taps land on bits 0,2,3,5
    localparam logic [15:0] LFSR_TAPS = 16'h002D;
    localparam int OVER_ATTEMPTS = 2;
    localparam int UNDER_ATTEMPTS = 2;
endpackage

// File: rtl/fifo_driver_lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR, shifts right with feedback into bit 15
//   clk, reset : clock, sync active-high reset (loads seed_i)
//   en_i       : advance one step
//   load_i     : load seed_i (wins over en_i)
//   seed_i     : seed value
//   state_o    : current register contents
module lfsr16
    import fifo_tb_pkg::*;
#(
    parameter logic [15:0] TAPS = LFSR_TAPS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en_i,
    input  logic        load_i,
    input  logic [15:0] seed_i,
    output logic [15:0] state_o
);
    logic [15:0] state_q;
    always_ff @(posedge clk) begin
        if (reset || load_i) state_q <= seed_i;
        else if (en_i)       state_q <= {^(state_q & TAPS), state_q[15:1]};
    end
    assign state_o = state_q;
endmodule

// File: rtl/fifo_driver.sv
// fifo_driver: phase-sequenced FIFO stimulus (fill/overfill/drain/underdrain/mixed) with flag cross-check
//   clk, reset     : clock, sync active-high reset
//   iSTART         : start pulse, honoured only in IDLE or DONE
//   iFULL, iEMPTY  : FIFO flags checked against the occupancy model
//   oENQ, oDEQ, oD : registered enqueue/dequeue strobes and enqueue data
//   oBUSY, oDONE   : run in progress / run finished
//   oERR           : sticky flag mismatch
module fifo_driver
    import fifo_tb_pkg::*;
#(
    parameter int          W    = 8,
    parameter int          S    = 16,
    parameter int          N    = 64,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         iSTART,
    input  logic         iFULL,
    input  logic         iEMPTY,
    output logic         oENQ,
    output logic         oDEQ,
    output logic [W-1:0] oD,
    output logic         oBUSY,
    output logic         oDONE,
    output logic         oERR
);
    localparam int OW   = $clog2(S + 1);
    localparam int PMAX = (S > N) ? S : N;
    localparam int PW   = $clog2(PMAX + 1);
    localparam logic [OW-1:0] OCC_FULL = OW'(S);

    state_e         state_q, state_d;
    logic [W-1:0]   wr_q, wr_d, d_q, d_d;
    logic [OW-1:0]  occ_q, occ_d, occ_prev_q;
    logic [PW-1:0]  ph_q, ph_d;
    logic           enq_q, enq_d, deq_q, deq_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic           strb_prev_q, accept, enq_ok, deq_ok, mis;
    logic [15:0]    lfsr;
    logic           unused_lfsr;

    lfsr16 u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .en_i   (state_q == MIXED),
        .load_i (accept),
        .seed_i (SEED),
        .state_o(lfsr)
    );
    assign unused_lfsr = ^lfsr[15:1];

    assign accept = iSTART && (state_q == IDLE || state_q == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_q        <= '0;
            occ_q       <= '0;
            occ_prev_q  <= '0;
            ph_q        <= '0;
            strb_prev_q <= 1'b0;
            enq_q       <= 1'b0;
            deq_q       <= 1'b0;
            d_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            occ_q       <= occ_d;
            occ_prev_q  <= accept ? '0 : occ_q;
            ph_q        <= ph_d;
            strb_prev_q <= enq_q | deq_q;
            enq_q       <= enq_d;
            deq_q       <= deq_d;
            d_q         <= d_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // FILL/DRAIN always strobe, so the phase ends on the strobe that makes occ full/empty
    always_comb begin
        state_d = state_q;
        if (accept) state_d = FILL;
        else begin
            unique case (state_q)
                FILL:       if (occ_q >= OW'(S - 1))             state_d = OVERFILL;
                OVERFILL:   if (ph_q == PW'(OVER_ATTEMPTS - 1))  state_d = DRAIN;
                DRAIN:      if (occ_q <= OW'(1))                 state_d = UNDERDRAIN;
                UNDERDRAIN: if (ph_q == PW'(UNDER_ATTEMPTS - 1)) state_d = MIXED;
                MIXED:      if (ph_q == PW'(N - 1))              state_d = DONE;
                default:    state_d = state_q;
            endcase
        end
    end

    // Flags lag the strobes by up to a cycle, so they are checked against the occupancy
    // one cycle back and only when no strobe was issued the cycle before that.
    always_comb begin
        enq_d  = (state_q == FILL && occ_q != OCC_FULL) || state_q == OVERFILL ||
                 (state_q == MIXED && lfsr[0] && occ_q != OCC_FULL);
        deq_d  = (state_q == DRAIN && occ_q != '0) || state_q == UNDERDRAIN ||
                 (state_q == MIXED && !lfsr[0] && occ_q != '0);
        enq_ok = enq_d && occ_q != OCC_FULL;
        deq_ok = deq_d && occ_q != '0;
        wr_d   = accept ? '0 : wr_q + W'(enq_ok);
        occ_d  = accept ? '0 : enq_ok ? occ_q + OW'(1) : deq_ok ? occ_q - OW'(1) : occ_q;
        ph_d   = (state_d != state_q) ? '0 : ph_q + PW'(1);
        d_d    = enq_d ? wr_q : d_q;
        mis    = !strb_prev_q && ((iFULL != (occ_prev_q == OCC_FULL)) || (iEMPTY != (occ_prev_q == '0)));
        err_d  = accept ? 1'b0 : err_q | mis;
        busy_d = accept || state_q inside {FILL, OVERFILL, DRAIN, UNDERDRAIN, MIXED};
        done_d = !accept && state_q == DONE;
    end

    assign oENQ  = enq_q;
    assign oDEQ  = deq_q;
    assign oD    = d_q;
    assign oBUSY = busy_q;
    assign oDONE = done_q;
    assign oERR  = err_q;
endmodule
